// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-side branch predictor: counter states, table entry
// layout and address-field helper widths.
// No ports; imported by branch_predictor and its counter sub-module.
package branch_predictor_pkg;

  typedef logic [63:0] word_t;
  typedef logic        bool;

  // 2-bit saturating counter states; the upper half predicts taken.
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_state_e;

  // The stored tag field is sized for the widest tag any legal configuration
  // can use (64-bit PC minus 2 byte-offset bits minus at least 2 index bits).
  // Narrower configurations zero-extend their tag into it.
  localparam int TAG_MAX = 60;

  typedef struct packed {
    bool                valid;
    logic [TAG_MAX-1:0] tag;
    word_t              target;
    cnt_state_e         cnt;
  } bp_entry_t;

  // PC bit positions for a table of 2**idx_bits entries.
  function automatic int tag_lo(input int idx_bits);
    return idx_bits + 2;
  endfunction

  function automatic int tag_hi(input int idx_bits, input int tag_bits);
    return idx_bits + tag_bits + 1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for a 2-bit saturating counter (SNT/WNT/WT/ST).
// Ports: cnt (current state), taken (resolved outcome), cnt_next (stepped state).
// Purely combinational; taken steps up, not-taken steps down, both clamp.
module branch_predictor_sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != 2'(ST)) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != 2'(SNT)) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: registered lookup for fetch, resolved-branch
// training from execute, and a running misprediction count.
// Ports: clk/reset; req_* lookup in, pred_* prediction out (1-cycle latency,
// held under stall); upd_* resolved branch in; mispredict / mispredict_cnt out.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 10,
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [63:0]         req_pc,
  input  logic                stall,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [63:0]         pred_target,
  input  logic                upd_valid,
  input  logic [63:0]         upd_pc,
  input  logic                upd_cond,
  input  logic                upd_taken,
  input  logic [63:0]         upd_target,
  input  logic                upd_pred_taken,
  input  logic [63:0]         upd_pred_target,
  output logic                mispredict,
  output logic [CNT_BITS-1:0] mispredict_cnt
);

  localparam int IDX    = $clog2(ENTRIES);
  localparam int TAG_LO = tag_lo(IDX);
  localparam int TAG_HI = tag_hi(IDX, TAG_BITS);

  bp_entry_t tbl [ENTRIES];

  logic [IDX-1:0]      req_idx, upd_idx;
  logic [TAG_BITS-1:0] req_tag, upd_tag;
  bp_entry_t           req_ent, upd_ent;
  logic                req_hit, req_taken;
  logic                upd_hit;
  logic [1:0]          upd_cnt_step;
  cnt_state_e          alloc_cnt;

  assign req_idx = req_pc[IDX+1:2];
  assign req_tag = req_pc[TAG_HI:TAG_LO];
  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[TAG_HI:TAG_LO];

  // Byte offset and PC bits above the tag do not take part in addressing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{req_pc[1:0], req_pc[63:TAG_HI+1],
                            upd_pc[1:0], upd_pc[63:TAG_HI+1]};

  // Lookup reads the table as it stood before this edge's update, so a
  // same-index lookup and update in one cycle returns the old entry.
  assign req_ent   = tbl[req_idx];
  assign req_hit   = req_ent.valid && (req_ent.tag == TAG_MAX'(req_tag));
  assign req_taken = req_hit && (req_ent.cnt >= WT);

  assign upd_ent = tbl[upd_idx];
  assign upd_hit = upd_ent.valid && (upd_ent.tag == TAG_MAX'(upd_tag));

  branch_predictor_sat_counter2 u_cnt (
    .cnt      (upd_ent.cnt),
    .taken    (upd_taken),
    .cnt_next (upd_cnt_step)
  );

  // Fresh conditional entries start weakly taken; jumps start strongly taken.
  always_comb begin
    alloc_cnt = ST;
    if (upd_cond) alloc_cnt = WT;
  end

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid     <= 1'b0;
      pred_taken     <= 1'b0;
      pred_target    <= '0;
      mispredict_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i].valid <= 1'b0;
      end
    end else begin
      // Lookup side: stall freezes every pred_* output.
      if (!stall) begin
        if (req_valid) begin
          pred_valid  <= 1'b1;
          pred_taken  <= req_taken;
          pred_target <= req_taken ? req_ent.target : '0;
        end else begin
          pred_valid <= 1'b0;
        end
      end

      // Training side.
      if (upd_valid) begin
        if (upd_hit) begin
          if (upd_cond) begin
            tbl[upd_idx].cnt <= cnt_state_e'(upd_cnt_step);
            if (upd_taken) tbl[upd_idx].target <= upd_target;
          end else begin
            tbl[upd_idx].cnt    <= ST;
            tbl[upd_idx].target <= upd_target;
          end
        end else if (upd_taken) begin
          // Taken miss replaces whatever entry occupied this slot.
          tbl[upd_idx].valid  <= 1'b1;
          tbl[upd_idx].tag    <= TAG_MAX'(upd_tag);
          tbl[upd_idx].target <= upd_target;
          tbl[upd_idx].cnt    <= alloc_cnt;
        end
      end

      if (mispredict) mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default parameters).
// Drives inputs 1 time unit after the rising edge and samples at the same point.
// Summary line reports comparison and failure counts.
module tb_branch_predictor;

  localparam int ENTRIES = 64;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_pc;
  logic        stall;
  logic        pred_valid;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_cond;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic        upd_pred_taken;
  logic [63:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] mispredict_cnt;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor #(.ENTRIES(ENTRIES), .TAG_BITS(10), .CNT_BITS(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_pc          (req_pc),
    .stall           (stall),
    .pred_valid      (pred_valid),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_cond        (upd_cond),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .mispredict_cnt  (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [63:0] pc);
    req_valid = 1'b1;
    req_pc    = pc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expect_pred(input string tag, input logic taken, input logic [63:0] tgt);
    check({tag, ".valid"},  {63'd0, pred_valid}, 64'd1);
    check({tag, ".taken"},  {63'd0, pred_taken}, {63'd0, taken});
    check({tag, ".target"}, pred_target, tgt);
  endtask

  task automatic set_upd(input logic [63:0] pc, input logic cond, input logic taken,
                         input logic [63:0] tgt, input logic ptaken, input logic [63:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_cond        = cond;
    upd_taken       = taken;
    upd_target      = tgt;
    upd_pred_taken  = ptaken;
    upd_pred_target = ptgt;
  endtask

  // Training update whose carried prediction matches the outcome (no mispredict).
  task automatic train(input logic [63:0] pc, input logic cond, input logic taken,
                       input logic [63:0] tgt);
    set_upd(pc, cond, taken, tgt, taken, tgt);
    tick();
    upd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_pc = '0; stall = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_cond = 1'b0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    tick(); tick();
    check("rst.pred_valid",  {63'd0, pred_valid}, 64'd0);
    check("rst.pred_taken",  {63'd0, pred_taken}, 64'd0);
    check("rst.pred_target", pred_target, 64'd0);
    check("rst.cnt",         {32'd0, mispredict_cnt}, 64'd0);
    reset = 1'b0;

    // Cold lookup misses.
    lookup(64'h8000_0000);
    expect_pred("cold", 1'b0, 64'd0);

    // Conditional allocate -> WT.
    train(64'h8000_0010, 1'b1, 1'b1, 64'h8000_0100);
    lookup(64'h8000_0010);
    expect_pred("cond_alloc", 1'b1, 64'h8000_0100);
    // Idle cycle: pred_valid drops, the rest hold.
    tick();
    check("idle.pred_valid",  {63'd0, pred_valid}, 64'd0);
    check("idle.pred_taken",  {63'd0, pred_taken}, 64'd1);
    check("idle.pred_target", pred_target, 64'h8000_0100);

    // WT -> WNT -> SNT.
    train(64'h8000_0010, 1'b1, 1'b0, 64'h8000_0014);
    train(64'h8000_0010, 1'b1, 1'b0, 64'h8000_0014);
    lookup(64'h8000_0010);
    expect_pred("cond_nt", 1'b0, 64'd0);

    // SNT -> 1 -> 2 -> 3 -> 3 (saturate), then one not-taken -> WT.
    for (int i = 0; i < 4; i++) train(64'h8000_0010, 1'b1, 1'b1, 64'h8000_0100);
    train(64'h8000_0010, 1'b1, 1'b0, 64'h8000_0014);
    lookup(64'h8000_0010);
    expect_pred("cond_sat", 1'b1, 64'h8000_0100);

    // Not-taken miss must not allocate.
    train(64'h8000_0030, 1'b1, 1'b0, 64'h8000_0034);
    lookup(64'h8000_0030);
    expect_pred("nt_miss", 1'b0, 64'd0);

    // JAL allocate, then alias on the same index with a different tag.
    train(64'h8000_0020, 1'b0, 1'b1, 64'h8000_0400);
    lookup(64'h8000_0020);
    expect_pred("jal", 1'b1, 64'h8000_0400);
    train(64'h8000_0020 + 4 * ENTRIES, 1'b1, 1'b1, 64'h8000_0500);
    lookup(64'h8000_0020);
    expect_pred("alias_old", 1'b0, 64'd0);
    lookup(64'h8000_0020 + 4 * ENTRIES);
    expect_pred("alias_new", 1'b1, 64'h8000_0500);

    // Stall holds pred_* while the request keeps changing.
    stall = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_pc = 64'h8000_0000 + 64'(i * 4);
      if (i == 2) req_valid = 1'b0;
      tick();
      expect_pred($sformatf("stall%0d", i), 1'b1, 64'h8000_0500);
    end
    stall = 1'b0;
    req_valid = 1'b0;

    // Same-cycle lookup and update to index 4: lookup sees the old entry.
    set_upd(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0600, 1'b1, 64'h8000_0600);
    req_valid = 1'b1;
    req_pc    = 64'h8000_0010;
    tick();
    upd_valid = 1'b0;
    req_valid = 1'b0;
    expect_pred("simul_old", 1'b1, 64'h8000_0100);
    lookup(64'h8000_0010);
    expect_pred("simul_new", 1'b1, 64'h8000_0600);

    // Mispredict accounting from a clean count.
    reset = 1'b1; tick(); reset = 1'b0;
    check("mp.cnt0", {32'd0, mispredict_cnt}, 64'd0);
    set_upd(64'h8000_0040, 1'b1, 1'b1, 64'h8000_0700, 1'b0, 64'd0);
    #1 check("mp.dir", {63'd0, mispredict}, 64'd1);
    tick();
    set_upd(64'h8000_0040, 1'b1, 1'b1, 64'h8000_0700, 1'b1, 64'h8000_0800);
    #1 check("mp.tgt", {63'd0, mispredict}, 64'd1);
    tick();
    set_upd(64'h8000_0040, 1'b1, 1'b0, 64'h8000_0700, 1'b0, 64'h8000_0800);
    #1 check("mp.ok", {63'd0, mispredict}, 64'd0);
    tick();
    upd_valid = 1'b0;
    #1 check("mp.idle", {63'd0, mispredict}, 64'd0);
    check("mp.cnt", {32'd0, mispredict_cnt}, 64'd2);

    // Reset mid-operation with a concurrent mispredicting update.
    for (int i = 0; i < 4; i++)
      train(64'h8000_1000 + 64'(i * 4), 1'b0, 1'b1, 64'h9000_0000 + 64'(i * 16));
    lookup(64'h8000_1004);
    expect_pred("pre_rst", 1'b1, 64'h9000_0010);
    reset = 1'b1;
    set_upd(64'h8000_1010, 1'b0, 1'b1, 64'h9000_0100, 1'b0, 64'd0);
    tick();
    reset = 1'b0;
    upd_valid = 1'b0;
    check("rst2.cnt",        {32'd0, mispredict_cnt}, 64'd0);
    check("rst2.pred_valid", {63'd0, pred_valid}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      lookup(64'h8000_1000 + 64'(i * 4));
      expect_pred($sformatf("rst2.miss%0d", i), 1'b0, 64'd0);
    end
    check("rst2.cnt_end", {32'd0, mispredict_cnt}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
